// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and limits for the UART receive path
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rx_timer_state_e;

    localparam int PRESC_MIN = 4;
    localparam int FRAME_MIN = 1;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: oversampling edge/bit counter with mid-bit sample window and frame strobes
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               restart,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [BIT_W-1:0]   frame_bits,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               sample_stb,
    output logic               sample_last,
    output logic               bit_tick,
    output logic               frame_done,
    output logic               busy
);

    rx_timer_state_e state, state_d;
    logic [PRESC_W-1:0] p_q, p_d, p_in, edge_d, mid;
    logic [BIT_W-1:0]   n_q, n_d, n_in, bit_d;

    assign p_in = (prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : prescale;
    assign n_in = (frame_bits < BIT_W'(FRAME_MIN)) ? BIT_W'(FRAME_MIN) : frame_bits;
    assign mid  = p_q >> 1;

    // P >= 4 keeps the whole window inside the bit, so no wrap handling is needed
    assign busy        = state == RUN;
    assign sample_stb  = busy && edge_cnt >= mid - PRESC_W'(1) && edge_cnt <= mid + PRESC_W'(1);
    assign sample_last = busy && edge_cnt == mid + PRESC_W'(1);
    assign bit_tick    = busy && edge_cnt == p_q - PRESC_W'(1);
    assign frame_done  = bit_tick && bit_cnt == n_q - BIT_W'(1);

    always_comb begin
        state_d = state;
        edge_d  = edge_cnt;
        bit_d   = bit_cnt;
        p_d     = p_q;
        n_d     = n_q;
        if (!enable) begin
            state_d = IDLE;
            edge_d  = '0;
            bit_d   = '0;
        end else if (state == IDLE || restart) begin
            state_d = RUN;
            edge_d  = '0;
            bit_d   = '0;
            p_d     = p_in;
            n_d     = n_in;
        end else if (state == RUN) begin
            state_d = frame_done ? DONE : RUN;
            edge_d  = bit_tick ? '0 : edge_cnt + PRESC_W'(1);
            bit_d   = frame_done ? '0 : bit_tick ? bit_cnt + BIT_W'(1) : bit_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_q      <= PRESC_W'(PRESC_MIN);
            n_q      <= BIT_W'(FRAME_MIN);
        end else begin
            state    <= state_d;
            edge_cnt <= edge_d;
            bit_cnt  <= bit_d;
            p_q      <= p_d;
            n_q      <= n_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer: directed vector table plus frame-level sequences for the bit timer
module tb_uart_rx_bit_timer;

    logic       clk = 0;
    logic       rst = 0;
    logic       enable = 0;
    logic       restart = 0;
    logic [5:0] prescale = 6'd8;
    logic [3:0] frame_bits = 4'd10;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_stb, sample_last, bit_tick, frame_done, busy;
    logic [14:0] got;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        rs;
        logic [5:0]  p;
        logic [3:0]  f;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [14];

    uart_rx_bit_timer #(.PRESC_W(6), .BIT_W(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .prescale(prescale), .frame_bits(frame_bits),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_stb(sample_stb),
        .sample_last(sample_last), .bit_tick(bit_tick), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign got = {edge_cnt, bit_cnt, sample_stb, sample_last, bit_tick, frame_done, busy};

    function automatic logic [14:0] mk(int e, int b, bit stb, bit last, bit tick, bit done, bit bsy);
        return {6'(e), 4'(b), stb, last, tick, done, bsy};
    endfunction

    // expected outputs at RUN cycle c of a frame with already-clamped P and N
    function automatic logic [14:0] model(int p, int n, int c);
        int e = c % p;
        int b = c / p;
        int m = p >> 1;
        bit tick = e == p - 1;
        return mk(e, b, e >= m - 1 && e <= m + 1, e == m + 1, tick, tick && b == n - 1, 1'b1);
    endfunction

    task automatic check(string name, logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got edge=%0d bit=%0d flags=%b exp edge=%0d bit=%0d flags=%b",
                     name, got[14:9], got[8:5], got[4:0], exp[14:9], exp[8:5], exp[4:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_seg(string name, int p, int n, int from, int to);
        for (int c = from; c <= to; c++) begin
            check($sformatf("%s_c%0d", name, c), model(p, n, c));
            if (c < to) step();
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 6'd2, 4'd0, mk(0, 0, 0, 0, 0, 0, 1)};
        tbl[1]  = '{1, 0, 6'd2, 4'd0, mk(1, 0, 1, 0, 0, 0, 1)};
        tbl[2]  = '{1, 0, 6'd2, 4'd0, mk(2, 0, 1, 0, 0, 0, 1)};
        tbl[3]  = '{1, 0, 6'd2, 4'd0, mk(3, 0, 1, 1, 1, 1, 1)};
        tbl[4]  = '{1, 0, 6'd2, 4'd0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1, 0, 6'd2, 4'd0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1, 1, 6'd4, 4'd2, mk(0, 0, 0, 0, 0, 0, 1)};
        tbl[7]  = '{1, 0, 6'd9, 4'd9, mk(1, 0, 1, 0, 0, 0, 1)};
        tbl[8]  = '{1, 0, 6'd9, 4'd9, mk(2, 0, 1, 0, 0, 0, 1)};
        tbl[9]  = '{1, 0, 6'd9, 4'd9, mk(3, 0, 1, 1, 1, 0, 1)};
        tbl[10] = '{1, 0, 6'd9, 4'd9, mk(0, 1, 0, 0, 0, 0, 1)};
        tbl[11] = '{1, 0, 6'd9, 4'd9, mk(1, 1, 1, 0, 0, 0, 1)};
        tbl[12] = '{0, 1, 6'd9, 4'd9, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{0, 1, 6'd9, 4'd9, mk(0, 0, 0, 0, 0, 0, 0)};

        #12;
        check("reset", mk(0, 0, 0, 0, 0, 0, 0));
        rst = 1;
        step();
        check("idle", mk(0, 0, 0, 0, 0, 0, 0));

        // clamp, DONE hold, restart from DONE, latching, abort priority
        for (int i = 0; i < 14; i++) begin
            enable = tbl[i].en;
            restart = tbl[i].rs;
            prescale = tbl[i].p;
            frame_bits = tbl[i].f;
            step();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        restart = 0;

        // full frame P=8 N=10
        prescale = 6'd8;
        frame_bits = 4'd10;
        enable = 1;
        step();
        frame_seg("p8", 8, 10, 0, 79);
        step();
        check("p8_done", mk(0, 0, 0, 0, 0, 0, 0));
        enable = 0;
        step();
        check("p8_idle", mk(0, 0, 0, 0, 0, 0, 0));

        // mid-frame prescale change ignored until restart
        enable = 1;
        step();
        frame_seg("latch8", 8, 10, 0, 2);
        prescale = 6'd16;
        step();
        frame_seg("latch8b", 8, 10, 3, 21);
        restart = 1;
        step();
        restart = 0;
        frame_seg("latch16", 16, 10, 0, 20);

        // asynchronous reset mid-frame
        #1;
        rst = 0;
        #1;
        check("async_rst", mk(0, 0, 0, 0, 0, 0, 0));
        enable = 0;
        #1;
        rst = 1;
        step();
        check("post_rst", mk(0, 0, 0, 0, 0, 0, 0));

        // widest prescale and frame length
        prescale = 6'd63;
        frame_bits = 4'd15;
        enable = 1;
        step();
        frame_seg("max", 63, 15, 0, 944);
        step();
        check("max_done", mk(0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
